// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: round-robin select generator and sampler for a 4:1 mux
//   Drives {S1,S0} over the enabled channels, holds each for DWELL cycles,
//   captures Y per channel and publishes a 4-bit snapshot after each pass.
//   Ports:
//     clk    - system clock, rising edge
//     rst    - synchronous active-high reset
//     start  - begin a pass (sampled in IDLE only)
//     stop   - abort, honoured in any state (wins over start)
//     ch_en  - channel enable mask, bit k enables mux input Ik
//     Y      - mux output fed back from the 4:1 mux
//     S1,S0  - mux select, {S1,S0} = channel index
//     sample - per-channel snapshot of Y
//     valid  - one-cycle pulse while a snapshot is being published
//     busy   - high in SETTLE and DONE
//   Optional: define MUX4_SCAN_CONT_EN for continuous back-to-back passes.
module mux4_scan_ctrl #(
   parameter int DWELL = 2,
   parameter int CW    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic [3:0] ch_en,
   input  logic       Y,
   output logic       S1,
   output logic       S0,
   output logic [3:0] sample,
   output logic       valid,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
   localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] sel_q, sel_d, low_en, nxt;
   logic [3:0] mask_q, mask_d, shadow_q, shadow_d, sample_q, sample_d;
   logic has_nxt;
   // lowest enabled channel of the live mask, used when a pass is (re)started
   always_comb begin
      low_en = '0;
      for (int k = 3; k >= 0; k--) if (ch_en[k]) low_en = 2'(k);
   end
   // next higher enabled channel of the latched mask above the current select
   always_comb begin
      nxt = sel_q;
      has_nxt = 1'b0;
      for (int k = 3; k >= 0; k--)
         if (mask_q[k] && k > int'(sel_q)) begin
            nxt = 2'(k);
            has_nxt = 1'b1;
         end
   end
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      sample_d = sample_q;
      if (stop) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE:
               if (start && ch_en != 4'd0) begin
                  mask_d  = ch_en;
                  sel_d   = low_en;
                  cnt_d   = RELOAD;
                  state_d = SETTLE;
               end
            SETTLE:
               if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
               else begin
                  shadow_d[sel_q] = Y;
                  if (has_nxt) begin
                     sel_d = nxt;
                     cnt_d = RELOAD;
                  end else state_d = DONE;
               end
            DONE: begin
               sample_d = shadow_q;
               state_d  = IDLE;
`ifdef MUX4_SCAN_CONT_EN
               if (ch_en != 4'd0) begin
                  mask_d  = ch_en;
                  sel_d   = low_en;
                  cnt_d   = RELOAD;
                  state_d = SETTLE;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sel_q    <= '0;
         mask_q   <= '0;
         shadow_q <= '0;
         sample_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         sample_q <= sample_d;
      end
   end
   // valid is masked by stop so the pulse only accompanies a real publish
   assign {S1, S0} = sel_q;
   assign sample   = sample_q;
   assign valid    = (state_q == DONE) && !stop;
   assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: directed vector bench for mux4_scan_ctrl
module tb_mux4_scan_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic start_a, stop_a, s1_a, s0_a, val_a, busy_a, y_a;
   logic [3:0] en_a, ypat_a, smp_a;
   logic start_b, stop_b, s1_b, s0_b, val_b, busy_b, y_b;
   logic [3:0] en_b, ypat_b, smp_b;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   assign y_a = ypat_a[{s1_a, s0_a}];
   assign y_b = ypat_b[{s1_b, s0_b}];
   mux4_scan_ctrl #(.DWELL(2), .CW(4)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .ch_en(en_a), .Y(y_a),
      .S1(s1_a), .S0(s0_a), .sample(smp_a), .valid(val_a), .busy(busy_a));
   mux4_scan_ctrl #(.DWELL(1), .CW(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .ch_en(en_b), .Y(y_b),
      .S1(s1_b), .S0(s0_b), .sample(smp_b), .valid(val_b), .busy(busy_b));
   typedef struct {
      logic [3:0]  en;
      logic [3:0]  ypat;
      logic [15:0] seq;
      int          n;
      logic [3:0]  exp;
   } vec_t;
   vec_t tv[4];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   initial begin
      logic ev, eb;
      // sel sequence packed two bits per SETTLE cycle, entry 0 in the LSBs
      tv[0] = '{en: 4'b0101, ypat: 4'b1111, seq: 16'h00A0, n: 4, exp: 4'b0101};
      tv[1] = '{en: 4'b1000, ypat: 4'b1111, seq: 16'h000F, n: 2, exp: 4'b1101};
      tv[2] = '{en: 4'b0110, ypat: 4'b0000, seq: 16'h00A5, n: 4, exp: 4'b1001};
      tv[3] = '{en: 4'b1111, ypat: 4'b1010, seq: 16'hFA50, n: 8, exp: 4'b1010};
      rst = 1'b1;
      start_a = 1'b1; stop_a = 1'b0; en_a = 4'hF; ypat_a = 4'h0;
      start_b = 1'b0; stop_b = 1'b0; en_b = 4'h0; ypat_b = 4'h0;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("reset", {2'b00, s1_a, s0_a, smp_a, val_a, busy_a}, 10'd0);
      end
      rst = 1'b0; start_a = 1'b0; en_a = 4'h0;
      tick();
      for (int i = 0; i < 4; i++) begin
         en_a = tv[i].en; ypat_a = tv[i].ypat; start_a = 1'b1;
         tick();
         start_a = 1'b0;
         for (int j = 0; j < tv[i].n; j++) begin
            if (j == 1) en_a = ~tv[i].en;
            chk("scan_sel", {6'd0, busy_a, val_a, s1_a, s0_a}, {6'd0, 2'b10, tv[i].seq[2*j +: 2]});
            tick();
         end
         en_a = 4'h0;
         chk("scan_valid", {8'd0, busy_a, val_a}, 10'b11);
         tick();
         chk("scan_done", {2'b00, busy_a, val_a, s1_a, s0_a, smp_a},
             {4'b0000, tv[i].seq[2*(tv[i].n-1) +: 2], tv[i].exp});
      end
      en_a = 4'hF; ypat_a = 4'h5; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      tick();
      stop_a = 1'b1;
      tick();
      stop_a = 1'b0;
      chk("abort_idle", {6'd0, busy_a, val_a, s1_a, s0_a}, 10'b0000000001);
      for (int c = 0; c < 10; c++) begin
         chk("abort_quiet", {4'd0, busy_a, val_a, smp_a}, 10'b0000001010);
         tick();
      end
      en_a = 4'h0; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      for (int c = 0; c < 10; c++) begin
         chk("empty_mask", {8'd0, busy_a, val_a}, 10'd0);
         tick();
      end
      en_a = 4'hF; start_a = 1'b1; stop_a = 1'b1;
      tick();
      start_a = 1'b0; stop_a = 1'b0; en_a = 4'h0;
      chk("start_stop", {8'd0, busy_a, val_a}, 10'd0);
      tick();
      en_a = 4'b0001; ypat_a = 4'hF; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      tick();
      chk("done_valid", {8'd0, busy_a, val_a}, 10'b11);
      stop_a = 1'b1;
      #1;
      chk("done_stop_valid", {9'd0, val_a}, 10'd0);
      tick();
      stop_a = 1'b0;
      chk("done_stop", {4'd0, busy_a, val_a, smp_a}, 10'b0000001010);
      ypat_a = 4'h0; start_a = 1'b1;
      tick();
      tick();
      tick();
      chk("held_valid", {8'd0, busy_a, val_a}, 10'b11);
      tick();
`ifdef MUX4_SCAN_CONT_EN
      chk("held_gap", {5'd0, busy_a, smp_a}, 10'b0000011010);
`else
      chk("held_gap", {5'd0, busy_a, smp_a}, 10'b0000001010);
`endif
      tick();
      chk("held_restart", {7'd0, busy_a, s1_a, s0_a}, 10'b0000000100);
      start_a = 1'b0; stop_a = 1'b1;
      tick();
      stop_a = 1'b0;
      chk("held_stop", {8'd0, busy_a, val_a}, 10'd0);
      en_a = 4'hF; ypat_a = 4'hF; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; en_a = 4'h0;
      chk("rst_mid", {2'b00, s1_a, s0_a, smp_a, val_a, busy_a}, 10'd0);
      tick();
      chk("rst_after", {8'd0, busy_a, val_a}, 10'd0);
      en_b = 4'b0011; ypat_b = 4'b0010; start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int c = 1; c <= 12; c++) begin
`ifdef MUX4_SCAN_CONT_EN
         ev = (c == 3) || (c == 6);
         eb = c <= 7;
`else
         ev = c == 3;
         eb = c <= 3;
`endif
         chk("dwell1", {8'd0, busy_b, val_b}, {8'd0, eb, ev});
         if (c <= 2) chk("dwell1_sel", {8'd0, s1_b, s0_b}, {8'd0, 1'b0, c == 2});
         stop_b = c == 7;
         tick();
      end
      stop_b = 1'b0;
      chk("dwell1_sample", {6'd0, smp_b}, 10'b0000000010);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
